// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller mapping 32-bit loads/stores onto a 16-bit async SRAM as two halfword phases.
// Optional stall counter output enabled by defining SRAM_STALL_CNT_EN.
module sram_mem_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
`ifdef SRAM_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  wcnt;
  logic        op_wr;
  logic [15:0] wdata_hi;
  logic [16:0] word_c;

  // Halfword-pair index of the requested word; offset bits above 18 alias away.
  assign word_c = 17'((address - 32'(BASE_ADDR)) >> 2);

  assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      op_wr       <= 1'b0;
      wdata_hi    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            state       <= LOW;
            op_wr       <= wr_en;
            wdata_hi    <= write_data[31:16];
            sram_addr   <= {word_c, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_we_n   <= ~wr_en;
            sram_dq_oe  <= wr_en;
            wcnt        <= '0;
          end
        end
        LOW: begin
          if (wcnt == WLAST) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            state       <= HIGH;
            sram_addr   <= {sram_addr[17:1], 1'b1};
            sram_dq_out <= wdata_hi;
            wcnt        <= '0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        HIGH: begin
          if (wcnt == WLAST) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            wcnt       <= '0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_STALL_CNT_EN
  // Saturating count of frozen pipeline cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl with a behavioural 16-bit SRAM model.
module tb_sram_mem_ctrl;

`ifdef SRAM_STALL_CNT_EN
  localparam int unsigned W = 3;
`else
  localparam int unsigned W = 2;
`endif
  localparam int unsigned BASE = 1024;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic [15:0] sram_dq_in;
`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [15:0] mem [256];
  logic        ld;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  logic [31:0] sb [$];
  logic [31:0] last_rd;
  int          n_cmp;
  int          n_err;

  sram_mem_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
`ifdef SRAM_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .sram_dq_in (sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write committed on each clock while we_n is low.
  assign sram_dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (ld) mem[ld_addr] <= ld_data;
    else if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full access starting now (just after a rising edge); returns just after the edge ending DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    logic [17:0] base;
    logic        hi;
    base = 18'(((addr - 32'(BASE)) >> 2) << 1);
    if (rd && !wr) sb.push_back({mem[8'(base + 18'd1)], mem[base[7:0]]});
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    for (int cyc = 0; cyc <= int'(2 * W + 1); cyc++) begin
      @(negedge clk);
      check("ready", 32'(ready), 32'(cyc == int'(2 * W + 1)));
      if (cyc >= 1 && cyc <= int'(2 * W)) begin
        hi = (cyc > int'(W));
        check("sram_addr", 32'(sram_addr), 32'(base + 18'(hi)));
        check("we_n", 32'(sram_we_n), 32'(!wr));
        check("dq_oe", 32'(sram_dq_oe), 32'(wr));
        if (wr) check("dq_out", 32'(sram_dq_out), hi ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
      end
      if (cyc == int'(2 * W + 1)) begin
        check("done_we_n", 32'(sram_we_n), 32'd1);
        if (rd && !wr) begin
          if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
          end else begin
            last_rd = sb.pop_front();
            check("read_data", read_data, last_rd);
          end
        end else begin
          check("read_hold", read_data, last_rd);
        end
      end
      @(posedge clk); #1;
      if (cyc == 0) begin
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_rd = '0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    ld = 1'b0; ld_addr = '0; ld_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      ld = 1'b1; ld_addr = 8'(i); ld_data = 16'(i * 16'h0111 + 7);
      if (i == 0) ld_data = 16'h1234;
      if (i == 1) ld_data = 16'hABCD;
      @(posedge clk); #1;
    end
    ld = 1'b0;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_oe", 32'(sram_dq_oe), 32'd0);
      if (i == 0) begin
        check("rst_read_data", read_data, 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
      end
    end
    @(posedge clk); #1;

    // Read of word 0 returns 0xABCD1234
    run_access(1'b1, 1'b0, 32'(BASE), 32'd0);
    check("rd0_value", read_data, 32'hABCD1234);

    // Store to halfwords 4/5
    run_access(1'b0, 1'b1, 32'(BASE + 8), 32'hDEADBEEF);
    check("mem4", 32'(mem[4]), 32'h0000BEEF);
    check("mem5", 32'(mem[5]), 32'h0000DEAD);

    // Simultaneous rd/wr performs the write
    run_access(1'b1, 1'b1, 32'(BASE), 32'h00000001);
    check("mem0", 32'(mem[0]), 32'h00000001);
    check("mem1", 32'(mem[1]), 32'h00000000);

    // Reset during HIGH phase of a read
    rd_en = 1'b1; address = 32'(BASE + 8);
    @(posedge clk); #1;
    rd_en = 1'b0; address = '0;
    for (int i = 0; i < int'(W) + 1; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_read_data", read_data, 32'd0);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    last_rd = '0;
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 32'(BASE + 16), 32'd0);

    // Back-to-back reads with no idle bubble
    run_access(1'b1, 1'b0, 32'(BASE + 8), 32'd0);
    run_access(1'b1, 1'b0, 32'(BASE + 4), 32'd0);
    check("b2b_value", read_data, {mem[3], mem[2]});

`ifdef SRAM_STALL_CNT_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("stall_clr", stall_cnt, 32'd0);
    last_rd = '0;
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 32'(BASE), 32'd0);
    run_access(1'b1, 1'b0, 32'(BASE + 8), 32'd0);
    @(negedge clk);
    check("stall_cnt", stall_cnt, 32'(2 * (2 * W + 1)));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("stall_rst", stall_cnt, 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Sequences the MEM-stage data-memory access onto an external 16-bit asynchronous SRAM.
- Splits each 32-bit load/store into two halfword phases and inserts programmable wait states per phase.
- Drives `ready`, which the pipeline uses as its freeze signal: all pipeline registers hold while `ready` = 0.
- Sits between the EXE/MEM pipeline register and the MEM/WB register; supplies the memory result for loads.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 2: cycles each halfword phase is held; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request from the MEM stage.
- wr_en  in  1  store request from the MEM stage.
- address  in  32  CPU byte address; word-aligned.
- write_data  in  32  store data.
- read_data  out  32  load result; registered.
- ready  out  1  1 = access complete or no access pending; 0 = freeze the pipeline.
- sram_addr  out  18  SRAM halfword address; registered.
- sram_dq_out  out  16  SRAM write data; registered.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_dq_in  in  16  SRAM read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State machine: IDLE, LOW, HIGH, DONE. Wait counter `wcnt` is 4 bits.
- IDLE to LOW: on a clock edge with (rd_en | wr_en) = 1. At that edge:
  - Latch op: write if wr_en = 1, else read. wr_en wins when rd_en and wr_en are both 1.
  - Latch off = address - BASE_ADDR (32-bit wrap) and write_data.
  - Set sram_addr = {off[18:2], 1'b0} and wcnt = 0.
- LOW: wcnt increments each cycle. When wcnt = WAIT_CYCLES-1:
  - Read: capture sram_dq_in into read_data[15:0].
  - Go to HIGH, set sram_addr = {off[18:2], 1'b1}, wcnt = 0.
- HIGH: same counting. When wcnt = WAIT_CYCLES-1:
  - Read: capture sram_dq_in into read_data[31:16].
  - Go to DONE.
- DONE: one cycle, then IDLE unconditionally.
- Write phases:
  - sram_we_n = 0 and sram_dq_oe = 1 for every cycle of LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Read phases: sram_we_n = 1 and sram_dq_oe = 0.
- IDLE/DONE outputs: sram_we_n = 1 and sram_dq_oe = 0.
- ready (combinational) = (state==IDLE & ~rd_en & ~wr_en) | (state==DONE).
- Latency:
  - Request first seen at cycle 0: ready = 0 in cycles 0..2*WAIT_CYCLES; ready = 1 in cycle 2*WAIT_CYCLES+1 (DONE).
  - read_data is valid in DONE and holds until the next read completes.
- Inputs are sampled only at the IDLE to LOW transition; changes while busy are ignored.
- Back-to-back requests: a request present in the cycle after DONE starts a new access; no idle bubble is required.
- Reset:
  - state = IDLE, wcnt = 0, read_data = 0, sram_addr = 0, sram_dq_out = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Reset mid-access aborts immediately; the partial SRAM write is not rolled back.
- Address range: off bits above 18 are ignored (aliasing); no error is flagged.

Optional Feature:
- Macro: SRAM_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt [31:0].
  - Increments by 1 on every cycle with ready = 0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Idle, rd_en = wr_en = 0 for 10 cycles -> ready = 1 throughout; sram_we_n = 1; sram_dq_oe = 0.
2. WAIT_CYCLES = 2; SRAM[0] = 0x1234, SRAM[1] = 0xABCD; rd_en with address = 1024 -> sram_addr 0 for cycles 1-2, then 1 for cycles 3-4; ready = 0 in cycles 0-4; cycle 5 ready = 1 with read_data = 0xABCD1234.
3. wr_en with address = 1032, write_data = 0xDEADBEEF, WAIT_CYCLES = 2:
   - sram_addr = 4, dq_out = 0xBEEF, we_n = 0 for 2 cycles;
   - then sram_addr = 5, dq_out = 0xDEAD for 2 cycles;
   - ready = 1 in cycle 5; SRAM model then holds 4 = 0xBEEF, 5 = 0xDEAD.
4. rd_en = wr_en = 1, address = 1024, write_data = 0x00000001 -> write performed; SRAM[0] = 0x0001, SRAM[1] = 0x0000; read_data unchanged.
5. rst asserted during the HIGH phase of a read -> next cycle state IDLE, read_data = 0, we_n = 1, ready = ~(rd_en|wr_en); a new read then completes normally with correct data.
6. SRAM_STALL_CNT_EN defined, WAIT_CYCLES = 3, two back-to-back reads -> stall_cnt = 14 after both complete; a subsequent rst gives stall_cnt = 0.
